// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: branch opcode window and the
// 2-bit saturating counter encoding with its update rule.
package fetch_pkg;

    localparam logic [5:0] BR_OP_LO = 6'b010011;
    localparam logic [5:0] BR_OP_HI = 6'b011001;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    function automatic ctr_e sat_update(input ctr_e cnt, input logic taken);
        ctr_e res;
        res = cnt;
        if (taken) begin
            if (cnt != ST) res = ctr_e'(cnt + 2'd1);
        end else begin
            if (cnt != SNT) res = ctr_e'(cnt - 2'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_unit_bht_if.sv
// Fetch-stage bus: EX feedback, instruction memory port and the IF/ID output.
// master = fetch unit, slave = surrounding pipeline / memory.
// Handshake: no backpressure; id_valid qualifies id_* every cycle, stall holds them.
interface fetch_unit_bht_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int IMEM_AW = 10
);
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               upd_valid;
    logic [PC_W-1:0]    upd_pc;
    logic               upd_taken;
    logic [IMEM_AW-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc_1;
    logic               id_pred_taken;
    logic [PC_W-1:0]    dbg_pc;

    modport master (
        input  stall, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, imem_rdata,
        output imem_addr, id_valid, id_instr, id_pc_1, id_pred_taken, dbg_pc
    );

    modport slave (
        output stall, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, imem_rdata,
        input  imem_addr, id_valid, id_instr, id_pc_1, id_pred_taken, dbg_pc
    );
endinterface

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating counters: one combinational read port and
// one clocked training port. Reads see the pre-update value.
module bht_2bit
    import fetch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_e             rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    ctr_e ctr_q [ENTRIES];
    ctr_e ctr_d [ENTRIES];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) ctr_d[wr_idx] = sat_update(ctr_q[wr_idx], wr_taken);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign rd_ctr = ctr_q[rd_idx];
endmodule

// File: rtl/fetch_unit_bht.sv
// Instruction-fetch stage: PC register, BHT-driven next-PC selection and
// the IF/ID register. Priority per edge: redirect > stall > normal fetch.
module fetch_unit_bht
    import fetch_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int INSTR_W     = 32,
    parameter int IMEM_AW     = 10,
    parameter int BHT_ENTRIES = 64
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_bht_if.master bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic               id_valid_q, id_valid_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [PC_W-1:0]    id_pc_1_q, id_pc_1_d;
    logic               id_pred_q, id_pred_d;

    logic [5:0]      opcode;
    logic            is_br;
    logic            pred;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] offset_sext;
    logic [PC_W-1:0] target;
    ctr_e            rd_ctr;

    assign opcode      = bus.imem_rdata[31:26];
    assign is_br       = (opcode >= BR_OP_LO) && (opcode <= BR_OP_HI);
    assign pc_plus1    = pc_q + PC_W'(1);
    assign offset_sext = {{(PC_W-16){bus.imem_rdata[15]}}, bus.imem_rdata[15:0]};
    assign target      = pc_plus1 + offset_sext;
    assign pred        = is_br & rd_ctr[1];

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_q[IDX_W-1:0]),
        .rd_ctr   (rd_ctr),
        .wr_en    (bus.upd_valid),
        .wr_idx   (bus.upd_pc[IDX_W-1:0]),
        .wr_taken (bus.upd_taken)
    );

    // Only the index bits of the resolved-branch PC address the table.
    logic unused_upd_pc;
    assign unused_upd_pc = ^bus.upd_pc[PC_W-1:IDX_W];

    always_comb begin
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_1_d  = id_pc_1_q;
        id_pred_d  = id_pred_q;
        if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            id_valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d       = pred ? target : pc_plus1;
            id_valid_d = 1'b1;
            id_instr_d = bus.imem_rdata;
            id_pc_1_d  = pc_plus1;
            id_pred_d  = pred;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_1_q  <= '0;
            id_pred_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_1_q  <= id_pc_1_d;
            id_pred_q  <= id_pred_d;
        end
    end

    assign bus.imem_addr     = pc_q[IMEM_AW-1:0];
    assign bus.id_valid      = id_valid_q;
    assign bus.id_instr      = id_instr_q;
    assign bus.id_pc_1       = id_pc_1_q;
    assign bus.id_pred_taken = id_pred_q;
    assign bus.dbg_pc        = pc_q;
endmodule
